// File: rtl/mux_nx1_pipe.sv
// N-input operand-select mux with a registered valid/ready output stage.
// A main register drives the outputs; one skid register absorbs the entry accepted while in_ready is still high.
module mux_nx1_pipe #(
  parameter int WIDTH = 64,
  parameter int N_IN  = 4,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              occupancy
);

  // Handshake: push = in_valid & in_ready, pop = out_valid & out_ready, both taken at the rising edge.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic               main_err_q, main_err_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               skid_err_q, skid_err_d;

  logic [WIDTH-1:0]   sel_data;
  logic               sel_err;
  logic               push;
  logic               pop;

  // An out-of-range select matches no input, leaving data at zero and err set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end else if (push) begin
          skid_data_d = sel_data;
          skid_err_d  = sel_err;
          state_d     = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops valid state only; data registers keep their stale contents.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = main_data_q;
      main_err_d  = main_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
    end
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b1;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: a vector table for the 4-input instance plus
// hand sequences for reset and the 3-input out-of-range case.
module tb_mux_nx1_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-input, 64-bit instance
  logic [255:0] a_in_data;
  logic [1:0]   a_in_sel;
  logic         a_in_valid, a_in_ready, a_flush;
  logic [63:0]  a_out_data;
  logic         a_out_err, a_out_valid, a_out_ready;
  logic [1:0]   a_occ;

  // 3-input, 16-bit instance
  logic [47:0]  b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_valid, b_in_ready, b_flush;
  logic [15:0]  b_out_data;
  logic         b_out_err, b_out_valid, b_out_ready;
  logic [1:0]   b_occ;

  mux_nx1_pipe #(.WIDTH(64), .N_IN(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .occupancy(a_occ)
  );

  mux_nx1_pipe #(.WIDTH(16), .N_IN(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .occupancy(b_occ)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        vld;
    logic        ordy;
    logic        fl;
    logic        e_vld;
    logic [63:0] e_data;
    logic        e_err;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  logic [63:0] in_vals [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic vld, input logic ordy,
                              input logic fl, input logic e_vld, input logic [63:0] e_data,
                              input logic [1:0] e_occ, input logic e_rdy);
    vec_t v;
    v.sel = sel; v.vld = vld; v.ordy = ordy; v.fl = fl;
    v.e_vld = e_vld; v.e_data = e_data; v.e_err = 1'b0; v.e_occ = e_occ; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic drive_a(input logic [1:0] sel, input logic vld, input logic ordy, input logic fl);
    @(negedge clk);
    a_in_sel = sel; a_in_valid = vld; a_out_ready = ordy; a_flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [1:0] sel, input logic vld, input logic ordy);
    @(negedge clk);
    b_in_sel = sel; b_in_valid = vld; b_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic e_vld, input logic [63:0] e_data,
                       input logic e_err, input logic [1:0] e_occ, input logic e_rdy);
    chk({tag, ".valid"}, 64'(a_out_valid), 64'(e_vld));
    if (e_vld) begin
      chk({tag, ".data"}, a_out_data, e_data);
      chk({tag, ".err"}, 64'(a_out_err), 64'(e_err));
    end
    chk({tag, ".occ"}, 64'(a_occ), 64'(e_occ));
    chk({tag, ".ready"}, 64'(a_in_ready), 64'(e_rdy));
  endtask

  initial begin
    in_vals[0] = 64'h11; in_vals[1] = 64'h22; in_vals[2] = 64'h33; in_vals[3] = 64'h44;
    a_in_data = {in_vals[3], in_vals[2], in_vals[1], in_vals[0]};
    a_in_sel = 2'd0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_data = '1;
    b_in_sel = 2'd0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;

    // select and latency
    tbl.push_back(mk(2'd2, 1, 1, 0, 1, 64'h33, 2'd1, 1));
    tbl.push_back(mk(2'd0, 0, 1, 0, 0, 64'h0,  2'd0, 1));
    // back-pressure and skid; third push is refused while in_ready is low
    tbl.push_back(mk(2'd0, 1, 0, 0, 1, 64'h11, 2'd1, 1));
    tbl.push_back(mk(2'd3, 1, 0, 0, 1, 64'h11, 2'd2, 0));
    tbl.push_back(mk(2'd1, 1, 0, 0, 1, 64'h11, 2'd2, 0));
    tbl.push_back(mk(2'd0, 0, 1, 0, 1, 64'h44, 2'd1, 1));
    tbl.push_back(mk(2'd0, 0, 1, 0, 0, 64'h0,  2'd0, 1));
    // streaming: 8 back-to-back pushes, one output per cycle
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(2'(i % 4), 1, 1, 0, 1, in_vals[i % 4], 2'd1, 1));
    tbl.push_back(mk(2'd0, 0, 1, 0, 0, 64'h0, 2'd0, 1));
    // flush at occupancy 2 with a concurrent push
    tbl.push_back(mk(2'd1, 1, 0, 0, 1, 64'h22, 2'd1, 1));
    tbl.push_back(mk(2'd3, 1, 0, 0, 1, 64'h22, 2'd2, 0));
    tbl.push_back(mk(2'd2, 1, 0, 1, 0, 64'h0,  2'd0, 1));
    tbl.push_back(mk(2'd0, 0, 1, 0, 0, 64'h0,  2'd0, 1));
    tbl.push_back(mk(2'd2, 1, 0, 1, 0, 64'h0,  2'd0, 1));
    tbl.push_back(mk(2'd0, 0, 1, 0, 0, 64'h0,  2'd0, 1));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 1'b0, 64'h0, 1'b0, 2'd0, 1'b1);
    chk("reset.data", a_out_data, 64'h0);
    chk("reset.err", 64'(a_out_err), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive_a(tbl[i].sel, tbl[i].vld, tbl[i].ordy, tbl[i].fl);
      chk_a($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_data, tbl[i].e_err,
            tbl[i].e_occ, tbl[i].e_rdy);
    end

    // reset mid-operation
    drive_a(2'd1, 1, 0, 0);
    drive_a(2'd2, 1, 0, 0);
    chk_a("pre_rst", 1'b1, 64'h22, 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_a("mid_rst", 1'b0, 64'h0, 1'b0, 2'd0, 1'b1);
    chk("mid_rst.data", a_out_data, 64'h0);
    chk("mid_rst.err", 64'(a_out_err), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_a(2'd1, 1, 1, 0);
    chk_a("post_rst", 1'b1, 64'h22, 1'b0, 2'd1, 1'b1);
    drive_a(2'd0, 0, 1, 0);
    chk_a("post_rst_drain", 1'b0, 64'h0, 1'b0, 2'd0, 1'b1);

    // out-of-range select on the 3-input instance, then an in-range entry via skid
    drive_b(2'd3, 1, 0);
    chk("oor.valid", 64'(b_out_valid), 64'h1);
    chk("oor.err", 64'(b_out_err), 64'h1);
    chk("oor.data", 64'(b_out_data), 64'h0);
    drive_b(2'd2, 1, 0);
    chk("oor.occ", 64'(b_occ), 64'h2);
    chk("oor.hold_err", 64'(b_out_err), 64'h1);
    drive_b(2'd0, 0, 1);
    chk("inr.err", 64'(b_out_err), 64'h0);
    chk("inr.data", 64'(b_out_data), 64'hFFFF);
    chk("inr.ready", 64'(b_in_ready), 64'h1);
    drive_b(2'd0, 0, 1);
    chk("b_drain.valid", 64'(b_out_valid), 64'h0);
    chk("b_drain.occ", 64'(b_occ), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
